// File: rtl/au_op_sequencer_pkg.sv
// rtl/au_op_sequencer_pkg.sv - shared encodings, FSM state type and instr field layout
// Contents: AU op codes, Y-select codes, sequencer states, instr field offsets,
//           and the rule that derives the effective Y select from op and field.
package au_op_sequencer_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] YSEL_S   = 2'b00;
  localparam logic [1:0] YSEL_IMM = 2'b01;
  localparam logic [1:0] YSEL_INV = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } seq_state_t;

  // instr = {op[1:0], ysel[1:0], dst, src_r, src_s}; src_s sits at bit 0
  function automatic int op_lsb(int ra);    return 3 * ra + 2; endfunction
  function automatic int ysel_lsb(int ra);  return 3 * ra;     endfunction
  function automatic int dst_lsb(int ra);   return 2 * ra;     endfunction
  function automatic int src_r_lsb(int ra); return ra;         endfunction

  // DIV always uses the reciprocal path, ADD/SUB never use Y, MUL takes the
  // field as given except the unused code 11, which falls back to S.
  function automatic logic [1:0] eff_ysel(logic [1:0] op, logic [1:0] ysel);
    logic [1:0] r;
    if (op == OP_DIV)       r = YSEL_INV;
    else if (op != OP_MUL)  r = YSEL_S;
    else if (ysel == 2'b11) r = YSEL_S;
    else                    r = ysel;
    return r;
  endfunction

endpackage

// File: rtl/au_op_sequencer_if.sv
// rtl/au_op_sequencer_if.sv - micro-op valid/ready stream
// Signals: instr_valid (op present), instr_ready (sequencer can take it),
//          instr {op, ysel, dst, src_r, src_s}. master = producer, slave = sequencer.
interface au_op_sequencer_if #(
  parameter int RA = 3
);
  localparam int IW = 4 + 3 * RA;

  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;

  modport master (output instr_valid, output instr, input  instr_ready);
  modport slave  (input  instr_valid, input  instr, output instr_ready);
endinterface

// File: rtl/au_op_sequencer_regfile.sv
// rtl/au_op_sequencer_regfile.sv - NREG x W register file for the AU sequencer
// Ports: one synchronous write port (we/waddr/wdata), two combinational operand
//        reads (a, b), a combinational host read, and the fixed immediate register.
module au_op_sequencer_regfile #(
  parameter int W       = 24,
  parameter int RA      = 3,
  parameter int IMM_REG = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RA-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [RA-1:0] raddr_a,
  input  logic [RA-1:0] raddr_b,
  input  logic [RA-1:0] host_addr,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b,
  output logic [W-1:0]  host_rdata,
  output logic [W-1:0]  imm_rdata
);
  localparam int            NREG     = 2 ** RA;
  localparam logic [RA-1:0] IMM_ADDR = RA'(IMM_REG);

  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a    = regs[raddr_a];
  assign rdata_b    = regs[raddr_b];
  assign host_rdata = regs[host_addr];
  assign imm_rdata  = regs[IMM_ADDR];

endmodule

// File: rtl/au_op_sequencer.sv
// rtl/au_op_sequencer.sv - issue stage: micro-op stream -> AU -> register writeback
// Ports: clk, rst_n; instr_if (slave stream); host_we/addr/wdata/rdata (preload and
//        readback, honoured only when idle); au_* pins to/from the AU; seq_busy;
//        err_timeout (sticky, cleared by err_clr); retired (writeback count, wraps).
module au_op_sequencer
  import au_op_sequencer_pkg::*;
#(
  parameter int W       = 24,
  parameter int FRAC    = 14,
  parameter int RA      = 3,
  parameter int IMM_REG = 7,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  au_op_sequencer_if.slave        instr_if,
  input  logic                    host_we,
  input  logic [RA-1:0]           host_addr,
  input  logic [W-1:0]            host_wdata,
  output logic [W-1:0]            host_rdata,
  output logic                    au_start,
  output logic [W-1:0]            au_r,
  output logic [W-1:0]            au_s,
  output logic [W-1:0]            au_iimm,
  output logic [1:0]              au_op_sel,
  output logic [1:0]              au_mul_y_sel,
  input  logic [W-1:0]            au_result,
  input  logic                    au_done,
  input  logic                    au_busy,
  output logic                    seq_busy,
  output logic                    err_timeout,
  input  logic                    err_clr,
  output logic [15:0]             retired
);
  localparam int            CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  seq_state_t    state;
  logic          started;
  logic [RA-1:0] dst_q;
  logic [CW-1:0] wait_cnt;

  logic [1:0]    f_op, f_ysel;
  logic [RA-1:0] f_dst, f_src_r, f_src_s;
  logic [W-1:0]  rd_r, rd_s;
  logic          accept, wb_fire, rf_we;
  logic [RA-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata;

  // The AU busy flag is observation-only and FRAC is a pass-through width.
  logic unused_ok;
  assign unused_ok = ^{au_busy, 32'(FRAC)};

  assign f_op    = instr_if.instr[op_lsb(RA) +: 2];
  assign f_ysel  = instr_if.instr[ysel_lsb(RA) +: 2];
  assign f_dst   = instr_if.instr[dst_lsb(RA) +: RA];
  assign f_src_r = instr_if.instr[src_r_lsb(RA) +: RA];
  assign f_src_s = instr_if.instr[0 +: RA];

  // 'started' keeps ready low until the first clock after reset release.
  assign instr_if.instr_ready = started && (state == ST_IDLE) && !host_we;
  assign accept   = instr_if.instr_valid && instr_if.instr_ready;
  assign seq_busy = (state != ST_IDLE);

  // Reciprocal results land the cycle au_done is seen; fixed ones in CAPTURE.
  assign wb_fire  = (state == ST_CAPTURE) ||
                    (state == ST_WAIT && au_mul_y_sel == YSEL_INV && au_done);
  assign rf_we    = wb_fire || (state == ST_IDLE && host_we);
  assign rf_waddr = wb_fire ? dst_q : host_addr;
  assign rf_wdata = wb_fire ? au_result : host_wdata;

  au_op_sequencer_regfile #(.W(W), .RA(RA), .IMM_REG(IMM_REG)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (rf_we),
    .waddr      (rf_waddr),
    .wdata      (rf_wdata),
    .raddr_a    (f_src_r),
    .raddr_b    (f_src_s),
    .host_addr  (host_addr),
    .rdata_a    (rd_r),
    .rdata_b    (rd_s),
    .host_rdata (host_rdata),
    .imm_rdata  (au_iimm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      started      <= 1'b0;
      au_start     <= 1'b0;
      au_r         <= '0;
      au_s         <= '0;
      au_op_sel    <= '0;
      au_mul_y_sel <= '0;
      dst_q        <= '0;
      wait_cnt     <= '0;
      err_timeout  <= 1'b0;
      retired      <= '0;
    end else begin
      started  <= 1'b1;
      au_start <= 1'b0;
      // Cleared first so that a timeout in the same cycle overrides the clear.
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            au_r         <= rd_r;
            au_s         <= rd_s;
            au_op_sel    <= f_op;
            au_mul_y_sel <= eff_ysel(f_op, f_ysel);
            dst_q        <= f_dst;
            au_start     <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (au_mul_y_sel != YSEL_INV) begin
            state <= ST_CAPTURE;
          end else if (au_done) begin
            retired <= retired + 16'd1;
            state   <= ST_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          retired <= retired + 16'd1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_au_op_sequencer.sv
// tb/tb_au_op_sequencer.sv - randomized bench for au_op_sequencer with a sign-magnitude AU stub
module tb_au_op_sequencer;
  localparam int W = 24, RA = 3, NREG = 8, TMO = 16, IMM = 7, FRAC = 14;
  localparam longint MAXM = (64'd1 << (W - 1)) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  au_op_sequencer_if #(.RA(RA)) bus ();
  logic          host_we = 1'b0;
  logic [RA-1:0] host_addr = '0;
  logic [W-1:0]  host_wdata = '0;
  logic [W-1:0]  host_rdata;
  logic          au_start;
  logic [W-1:0]  au_r, au_s, au_iimm, au_result;
  logic [1:0]    au_op_sel, au_mul_y_sel;
  logic          au_done, au_busy;
  logic          seq_busy, err_timeout;
  logic          err_clr = 1'b0;
  logic [15:0]   retired;

  int total = 0, bad = 0, cyc = 0, next_lat = 0;
  bit chk_en = 0;

  au_op_sequencer #(.W(W), .FRAC(FRAC), .RA(RA), .IMM_REG(IMM), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .instr_if(bus),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .au_start(au_start), .au_r(au_r), .au_s(au_s), .au_iimm(au_iimm),
    .au_op_sel(au_op_sel), .au_mul_y_sel(au_mul_y_sel), .au_result(au_result),
    .au_done(au_done), .au_busy(au_busy), .seq_busy(seq_busy),
    .err_timeout(err_timeout), .err_clr(err_clr), .retired(retired)
  );

  // ---------------- sign-magnitude arithmetic ----------------
  function automatic longint mag(input logic [W-1:0] x);
    return longint'(x[W-2:0]);
  endfunction

  function automatic logic [W-1:0] pack(input logic s, input longint m);
    longint mm;
    mm = (m > MAXM) ? MAXM : m;
    return {s, mm[W-2:0]};
  endfunction

  function automatic logic [W-1:0] au_calc(input logic [1:0] op, input logic [1:0] ysel,
                                           input logic [W-1:0] r, input logic [W-1:0] s,
                                           input logic [W-1:0] imm);
    longint a, b;
    logic [W-1:0] y;
    if (ysel == 2'd2) begin
      if (mag(s) == 0) return pack(r[W-1] ^ s[W-1], MAXM);
      return pack(r[W-1] ^ s[W-1], (mag(r) << FRAC) / mag(s));
    end
    if (op[1]) begin
      y = (ysel == 2'd1) ? imm : s;
      return pack(r[W-1] ^ y[W-1], (mag(r) * mag(y)) >> FRAC);
    end
    a = r[W-1] ? -mag(r) : mag(r);
    b = s[W-1] ? -mag(s) : mag(s);
    if (op[0]) b = -b;
    a = a + b;
    return pack(a < 0, (a < 0) ? -a : a);
  endfunction

  // ---------------- AU stub: result from pins, done after the op's latency ----------------
  int dcnt = -1;
  int m_lat = 0;
  always @(posedge clk) begin
    if (au_start)      dcnt <= (au_mul_y_sel == 2'd2) ? m_lat : -1;
    else if (dcnt > 0) dcnt <= dcnt - 1;
    else               dcnt <= -1;
  end
  assign au_done = (dcnt == 0);
  assign au_busy = (dcnt >= 0);
  always_comb au_result = au_calc(au_op_sel, au_mul_y_sel, au_r, au_s, au_iimm);

  // ---------------- behavioural model: an op occupies the unit for a known number of cycles ----------------
  logic [W-1:0]  m_regs [NREG];
  logic [W-1:0]  m_r = '0, m_s = '0;
  logic [1:0]    m_op = '0, m_ysel = '0;
  logic [RA-1:0] m_dst = '0;
  logic [15:0]   m_retired = '0;
  int  m_left = 0, m_elapsed = 0;
  bit  m_started = 0, m_err = 0, m_tmo = 0;

  task automatic model_step();
    logic [1:0] op, ys;
    logic [RA-1:0] d, sr, ss;
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_left = 0; m_elapsed = 0; m_started = 0; m_err = 0; m_retired = '0;
      return;
    end
    if (err_clr) m_err = 0;
    if (m_left == 0) begin
      if (host_we) m_regs[host_addr] = host_wdata;
      else if (bus.instr_valid && m_started) begin
        {op, ys, d, sr, ss} = bus.instr;
        m_op = op;
        m_ysel = (op == 2'd3) ? 2'd2 : (op != 2'd2) ? 2'd0 : (ys == 2'd3) ? 2'd0 : ys;
        m_dst = d; m_r = m_regs[sr]; m_s = m_regs[ss];
        m_lat = next_lat; m_elapsed = 0;
        m_tmo = (m_ysel == 2'd2) && (m_lat >= TMO);
        m_left = (m_ysel != 2'd2) ? 3 : (m_tmo ? 1 + TMO : 2 + m_lat);
      end
    end else begin
      m_left--; m_elapsed++;
      if (m_left == 0) begin
        if (m_tmo) m_err = 1;
        else begin
          m_regs[m_dst] = au_calc(m_op, m_ysel, m_r, m_s, m_regs[IMM]);
          m_retired++;
        end
      end
    end
    m_started = 1;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en) begin
      chk("ready", 32'(bus.instr_ready), 32'(m_started && m_left == 0 && !host_we));
      chk("seq_busy", 32'(seq_busy), 32'(m_left != 0));
      chk("au_start", 32'(au_start), 32'(m_left != 0 && m_elapsed == 0));
      chk("retired", 32'(retired), 32'(m_retired));
      chk("err_timeout", 32'(err_timeout), 32'(m_err));
      chk("host_rdata", 32'(host_rdata), 32'(m_regs[host_addr]));
      chk("au_iimm", 32'(au_iimm), 32'(m_regs[IMM]));
      if (m_left != 0) begin
        chk("au_r", 32'(au_r), 32'(m_r));
        chk("au_s", 32'(au_s), 32'(m_s));
        chk("au_op_sel", 32'(au_op_sel), 32'(m_op));
        chk("au_mul_y_sel", 32'(au_mul_y_sel), 32'(m_ysel));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic hw(input int a, input logic [W-1:0] d);
    @(posedge clk); #1;
    host_we = 1'b1; host_addr = RA'(a); host_wdata = d;
    @(posedge clk); #1;
    host_we = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] ys, input int d, input int sr,
                      input int ss, input int lat, output int acc);
    int n;
    @(posedge clk); #1;
    next_lat = lat;
    bus.instr = {op, ys, RA'(d), RA'(sr), RA'(ss)};
    bus.instr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.instr_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin total++; bad++; $display("FAIL send: no accept within bound"); end
    acc = cyc;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (seq_busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin total++; bad++; $display("FAIL wait_idle: still busy"); end
  endtask

  task automatic rd(input int a, input logic [W-1:0] exp, input string name);
    @(posedge clk); #1;
    host_addr = RA'(a);
    @(negedge clk);
    chk(name, 32'(host_rdata), 32'(exp));
  endtask

  // ---------------- main sequence ----------------
  int a0, a1;
  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    #12;
    chk("rst_ready", 32'(bus.instr_ready), 32'd0);
    chk("rst_busy", 32'(seq_busy), 32'd0);
    chk("rst_start", 32'(au_start), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_rdata", 32'(host_rdata), 32'd0);
    chk("rst_au_r", 32'(au_r), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("ready_before_first_clk", 32'(bus.instr_ready), 32'd0);
    chk_en = 1;

    // ADD and fixed-path throughput
    hw(1, 24'h008000); hw(2, 24'h00C000);
    send(2'd0, 2'd0, 3, 1, 2, 0, a0);
    send(2'd0, 2'd0, 0, 0, 0, 0, a1);
    chk("a2a_fixed", 32'(a1 - a0), 32'd4);
    wait_idle();
    rd(3, 24'h014000, "add_r3");
    chk("retired_after_two", 32'(retired), 32'd2);

    // SUB into its own source
    hw(1, 24'h014000); hw(2, 24'h01C000);
    send(2'd1, 2'd0, 1, 1, 2, 0, a0);
    wait_idle();
    rd(1, 24'h808000, "sub_r1");

    // MUL with S, IMM and the reserved select code
    hw(2, 24'h00C000);
    hw(7, 24'h004000);
    send(2'd2, 2'd0, 4, 1, 2, 0, a0);
    send(2'd2, 2'd1, 5, 1, 2, 0, a0);
    send(2'd2, 2'd3, 6, 1, 2, 0, a0);
    wait_idle();
    rd(4, 24'h818000, "mul_s");
    rd(5, 24'h808000, "mul_imm");
    rd(6, 24'h818000, "mul_ysel3");

    // DIV on the reciprocal path
    hw(1, 24'h010000); hw(2, 24'h008000);
    send(2'd3, 2'd0, 3, 1, 2, 5, a0);
    send(2'd0, 2'd0, 0, 0, 0, 0, a1);
    chk("a2a_div_lat5", 32'(a1 - a0), 32'd8);
    wait_idle();
    rd(3, 24'h008000, "div_r3");

    // last cycle before timeout still writes back
    hw(3, 24'h000000);
    send(2'd3, 2'd0, 3, 1, 2, TMO - 1, a0);
    send(2'd0, 2'd0, 0, 0, 0, 0, a1);
    chk("a2a_div_edge", 32'(a1 - a0), 32'(2 + TMO));
    wait_idle();
    rd(3, 24'h008000, "div_edge_r3");
    chk("no_err_edge", 32'(err_timeout), 32'd0);

    // reciprocal MUL whose done never arrives
    send(2'd2, 2'd2, 6, 1, 2, 1000, a0);
    send(2'd0, 2'd0, 0, 0, 0, 0, a1);
    chk("a2a_timeout", 32'(a1 - a0), 32'(2 + TMO));
    wait_idle();
    chk("err_set", 32'(err_timeout), 32'd1);
    rd(6, 24'h818000, "timeout_dst_kept");
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(err_timeout), 32'd0);

    // host write beats a simultaneous micro-op
    @(posedge clk); #1;
    host_we = 1'b1; host_addr = 3'd2; host_wdata = 24'h001000;
    bus.instr = {2'd0, 2'd0, 3'd0, 3'd2, 3'd2}; bus.instr_valid = 1'b1; next_lat = 0;
    @(negedge clk);
    chk("hw_prio_ready", 32'(bus.instr_ready), 32'd0);
    @(posedge clk); #1 host_we = 1'b0;
    @(negedge clk);
    chk("hw_then_ready", 32'(bus.instr_ready), 32'd1);
    @(posedge clk); #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("hw_then_busy", 32'(seq_busy), 32'd1);
    wait_idle();
    rd(0, 24'h002000, "hw_prio_result");

    // host write while busy is dropped
    send(2'd3, 2'd0, 4, 1, 2, 8, a0);
    @(posedge clk); #1 host_we = 1'b1; host_addr = 3'd1; host_wdata = 24'hABCDEF;
    @(posedge clk); #1 host_we = 1'b0;
    wait_idle();
    rd(1, 24'h010000, "hw_busy_dropped");

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      bus.instr_valid = ($urandom_range(0, 1) == 1);
      bus.instr = 13'($urandom);
      host_we = ($urandom_range(0, 9) == 0);
      host_addr = RA'($urandom);
      host_wdata = W'($urandom);
      err_clr = ($urandom_range(0, 19) == 0);
      next_lat = $urandom_range(0, 19);
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0; host_we = 1'b0; err_clr = 1'b0;
    wait_idle();

    // reset in the middle of a DIV
    hw(1, 24'h010000); hw(2, 24'h008000);
    send(2'd3, 2'd0, 3, 1, 2, 12, a0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(seq_busy), 32'd0);
    chk("mid_rst_start", 32'(au_start), 32'd0);
    chk("mid_rst_au_r", 32'(au_r), 32'd0);
    chk("mid_rst_au_s", 32'(au_s), 32'd0);
    chk("mid_rst_op", 32'(au_op_sel), 32'd0);
    chk("mid_rst_ysel", 32'(au_mul_y_sel), 32'd0);
    chk("mid_rst_retired", 32'(retired), 32'd0);
    chk("mid_rst_err", 32'(err_timeout), 32'd0);
    chk("mid_rst_ready", 32'(bus.instr_ready), 32'd0);
    chk("mid_rst_rdata", 32'(host_rdata), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
